bcd_conv_seq: RTL and testbench

//  Sequential binary-to-BCD converter feeding the 7-segment display driver.

---
 rtl/bcd_pkg.sv | 21 ++
 rtl/bcd_conv_seq_dabble_step.sv | 26 ++
 rtl/bcd_conv_seq.sv | 138 +++++++++++++
 tb/tb_bcd_conv_seq.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and sizing for the sequential binary-to-BCD converter.
package bcd_pkg;

  localparam int W_BIN = 10;
  localparam int N_CH  = 3;
  localparam int N_DIG = 3;
  localparam int W_DEC = 4 * N_DIG;
  // One extra digit so the largest 10-bit value converts without loss.
  localparam int W_SCR = 4 * (N_DIG + 1);
  localparam int W_CNT = $clog2(W_BIN);
  localparam int W_CH  = $clog2(N_CH);

  localparam logic [W_DEC-1:0] BCD_MAX = 12'h999;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_conv_seq_dabble_step.sv
// One double-dabble iteration: add 3 to every nibble >= 5, then shift left
// by one, bringing in the next binary bit.
module dabble_step
  import bcd_pkg::*;
(
  input  logic [W_SCR-1:0] bcd_in,
  input  logic             bit_in,
  output logic [W_SCR-1:0] bcd_out
);

  logic [W_SCR-1:0] adj;

  generate
    for (genvar gi = 0; gi < N_DIG + 1; gi++) begin : g_nib
      assign adj[4*gi +: 4] = (bcd_in[4*gi +: 4] >= 4'd5) ?
                              (bcd_in[4*gi +: 4] + 4'd3) : bcd_in[4*gi +: 4];
    end
  endgenerate

  assign bcd_out = {adj[W_SCR-2:0], bit_in};

  // The top bit can never be set for inputs below 2^W_BIN.
  logic unused_msb;
  assign unused_msb = adj[W_SCR-1];

endmodule

// File: rtl/bcd_conv_seq.sv
// Sequential three-channel binary-to-BCD converter (shift-add-3).
// Optional saturation of values above 999 with BCDCONV_SAT_EN.
module bcd_conv_seq
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             RSTn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W_BIN-1:0] bin0,
  input  logic [W_BIN-1:0] bin1,
  input  logic [W_BIN-1:0] bin2,
  output logic [W_DEC-1:0] dec0,
  output logic [W_DEC-1:0] dec1,
  output logic [W_DEC-1:0] dec2,
  output logic             out_valid,
  output logic [N_CH-1:0]  ovf
);

  state_t state_reg, state_next;

  logic [W_BIN-1:0] bin_in      [N_CH];
  logic [W_BIN-1:0] shadow_reg  [N_CH];
  logic [W_SCR-1:0] res_reg     [N_CH-1];
  logic [W_SCR-1:0] src         [N_CH];
  logic [W_DEC-1:0] dec_reg     [N_CH];
  logic [W_DEC-1:0] dec_next    [N_CH];
  logic [N_CH-1:0]  ovf_reg, ovf_next;
  logic [W_SCR-1:0] scratch_reg;
  logic [W_SCR-1:0] step_out;
  logic [W_CNT-1:0] bit_cnt_reg;
  logic [W_CH-1:0]  ch_cnt_reg;
  logic             last_bit, last_ch, capture;

  assign bin_in[0] = bin0;
  assign bin_in[1] = bin1;
  assign bin_in[2] = bin2;

  assign capture  = (state_reg == IDLE) && in_valid;
  assign last_bit = (state_reg == SHIFT) && (bit_cnt_reg == W_CNT'(W_BIN - 1));
  assign last_ch  = (ch_cnt_reg == W_CH'(N_CH - 1));

  // shadow_reg[0] always holds the channel in progress, MSB first.
  dabble_step u_step (
    .bcd_in  (scratch_reg),
    .bit_in  (shadow_reg[0][W_BIN-1]),
    .bcd_out (step_out)
  );

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = SHIFT;
      SHIFT:   if (last_bit && last_ch) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_reg == IDLE);
    out_valid = (state_reg == DONE);
  end

  // The final channel is taken straight from the step so the outputs land
  // on the same edge that enters DONE.
  logic [N_CH-1:0] thousands_nz;
  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_out
      if (gi == N_CH - 1) begin : g_last
        assign src[gi] = step_out;
      end else begin : g_res
        assign src[gi] = res_reg[gi];
      end
      assign thousands_nz[gi] = (src[gi][W_SCR-1 -: 4] != 4'd0);
`ifdef BCDCONV_SAT_EN
      assign dec_next[gi] = thousands_nz[gi] ? BCD_MAX : src[gi][W_DEC-1:0];
      assign ovf_next[gi] = thousands_nz[gi];
`else
      assign dec_next[gi] = src[gi][W_DEC-1:0];
      assign ovf_next[gi] = 1'b0;
`endif
    end
  endgenerate

  logic unused_thousands;
  assign unused_thousands = ^thousands_nz;

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < N_CH; i++) begin
        shadow_reg[i] <= '0;
        dec_reg[i]    <= '0;
      end
      for (int i = 0; i < N_CH - 1; i++) res_reg[i] <= '0;
      scratch_reg <= '0;
      bit_cnt_reg <= '0;
      ch_cnt_reg  <= '0;
      ovf_reg     <= '0;
    end else if (capture) begin
      for (int i = 0; i < N_CH; i++) shadow_reg[i] <= bin_in[i];
      scratch_reg <= '0;
      bit_cnt_reg <= '0;
      ch_cnt_reg  <= '0;
    end else if (state_reg == SHIFT) begin
      if (last_bit) begin
        scratch_reg <= '0;
        bit_cnt_reg <= '0;
        if (last_ch) begin
          for (int i = 0; i < N_CH; i++) dec_reg[i] <= dec_next[i];
          ovf_reg <= ovf_next;
        end else begin
          for (int i = 0; i < N_CH - 1; i++) begin
            if (ch_cnt_reg == W_CH'(i)) res_reg[i] <= step_out;
          end
          for (int i = 0; i < N_CH - 1; i++) shadow_reg[i] <= shadow_reg[i+1];
          shadow_reg[N_CH-1] <= '0;
          ch_cnt_reg <= ch_cnt_reg + 1'b1;
        end
      end else begin
        scratch_reg   <= step_out;
        shadow_reg[0] <= {shadow_reg[0][W_BIN-2:0], 1'b0};
        bit_cnt_reg   <= bit_cnt_reg + 1'b1;
      end
    end
  end

  assign dec0 = dec_reg[0];
  assign dec1 = dec_reg[1];
  assign dec2 = dec_reg[2];
  assign ovf  = ovf_reg;

endmodule

// File: tb/tb_bcd_conv_seq.sv
// Self-checking bench for bcd_conv_seq: directed cases, mid-run reset and
// random conversions compared against a decimal-arithmetic model.
module tb_bcd_conv_seq;

  logic        clk = 1'b0;
  logic        RSTn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [9:0]  bin0 = '0, bin1 = '0, bin2 = '0;
  logic [11:0] dec0, dec1, dec2;
  logic        out_valid;
  logic [2:0]  ovf;

  int checks = 0;
  int errors = 0;
  logic [11:0] prev_dec [3];

  bcd_conv_seq dut (
    .clk       (clk),
    .RSTn      (RSTn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bin0      (bin0),
    .bin1      (bin1),
    .bin2      (bin2),
    .dec0      (dec0),
    .dec1      (dec1),
    .dec2      (dec2),
    .out_valid (out_valid),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [11:0] exp_dec(input int v);
    int r;
`ifdef BCDCONV_SAT_EN
    r = (v > 999) ? 999 : v;
`else
    r = v % 1000;
`endif
    return {4'(r / 100), 4'((r / 10) % 10), 4'(r % 10)};
  endfunction

  function automatic logic [2:0] exp_ovf(input int b0, input int b1, input int b2);
`ifdef BCDCONV_SAT_EN
    return {b2 > 999, b1 > 999, b0 > 999};
`else
    return 3'b000 & {b2 > 999, b1 > 999, b0 > 999};
`endif
  endfunction

  task automatic do_conv(input int b0, input int b1, input int b2, input bit inject);
    int waited, bad_busy, bad_hold;
    waited = 0;
    while (in_ready !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("ready_before", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    bin0 = 10'(b0); bin1 = 10'(b1); bin2 = 10'(b2);
    @(posedge clk);
    bad_busy = 0;
    bad_hold = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1) in_valid = 1'b0;
      if (inject && k == 5) begin
        in_valid = 1'b1;
        bin0 = 10'd111; bin1 = 10'd222; bin2 = 10'd333;
      end
      if (inject && k == 6) in_valid = 1'b0;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) bad_busy++;
      if (dec0 !== prev_dec[0] || dec1 !== prev_dec[1] || dec2 !== prev_dec[2]) bad_hold++;
    end
    check("busy_flags", 32'(bad_busy), 32'd0);
    check("dec_hold", 32'(bad_hold), 32'd0);
    @(negedge clk);
    check("out_valid_t31", 32'(out_valid), 32'd1);
    check("in_ready_t31", 32'(in_ready), 32'd0);
    check("dec0", 32'(dec0), 32'(exp_dec(b0)));
    check("dec1", 32'(dec1), 32'(exp_dec(b1)));
    check("dec2", 32'(dec2), 32'(exp_dec(b2)));
    check("ovf", 32'(ovf), 32'(exp_ovf(b0, b1, b2)));
    @(negedge clk);
    check("in_ready_t32", 32'(in_ready), 32'd1);
    check("out_valid_t32", 32'(out_valid), 32'd0);
    check("dec0_hold_idle", 32'(dec0), 32'(exp_dec(b0)));
    $display("conv bin=%0d,%0d,%0d dec=%03h,%03h,%03h ovf=%b", b0, b1, b2, dec0, dec1, dec2, ovf);
    prev_dec[0] = exp_dec(b0);
    prev_dec[1] = exp_dec(b1);
    prev_dec[2] = exp_dec(b2);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_dec0"}, 32'(dec0), 32'h0);
    check({tag, "_dec1"}, 32'(dec1), 32'h0);
    check({tag, "_dec2"}, 32'(dec2), 32'h0);
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_ovf"}, 32'(ovf), 32'd0);
  endtask

  initial begin
    int bad_valid;
    int r0, r1, r2;
    for (int i = 0; i < 3; i++) prev_dec[i] = 12'h000;

    repeat (3) @(negedge clk);
    check_reset_state("reset");
    RSTn = 1'b1;
    @(negedge clk);
    check_reset_state("after_reset");
    $display("reset released");

    do_conv(0, 9, 10, 1'b0);
    do_conv(255, 999, 512, 1'b0);
    do_conv(1023, 1000, 7, 1'b0);
    do_conv(321, 654, 987, 1'b1);

    // Abort a conversion at T+15.
    @(negedge clk);
    in_valid = 1'b1;
    bin0 = 10'd500; bin1 = 10'd600; bin2 = 10'd700;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (14) @(negedge clk);
    RSTn = 1'b0;
    #1;
    check_reset_state("mid_reset");
    $display("reset asserted mid-conversion");
    repeat (2) @(negedge clk);
    RSTn = 1'b1;
    for (int i = 0; i < 3; i++) prev_dec[i] = 12'h000;
    bad_valid = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid !== 1'b0) bad_valid++;
    end
    check("no_valid_after_abort", 32'(bad_valid), 32'd0);
    check_reset_state("idle_after_abort");
    do_conv(42, 100, 999, 1'b0);

    for (int n = 0; n < 20; n++) begin
      r0 = int'($urandom_range(0, 1023));
      r1 = int'($urandom_range(0, 1023));
      r2 = (n % 4 == 0) ? int'($urandom_range(1000, 1023)) : int'($urandom_range(0, 999));
      do_conv(r0, r1, r2, n[0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
